// File: rtl/imem_boot_ctrl.sv
// Boot/load controller for a 32x32 instruction memory: fills it from a byte stream
// while holding the CPU in reset, then hands the read address to the CPU fetch PC.
module imem_boot_ctrl #(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_start,
   input  logic [CNT_W-1:0]  load_len,
   input  logic              rx_valid,
   input  logic [7:0]        rx_byte,
   output logic              rx_ready,
   input  logic [31:0]       cpu_pc,
   output logic [ADDR_W-1:0] im_addr,
   output logic              im_we,
   output logic [31:0]       im_wdata,
   output logic              cpu_rst_n,
   output logic              load_done,
   output logic              fetch_fault,
   output logic [1:0]        fsm_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_WRITE = 2'd2,
      S_RUN   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [31:0]      PC_LIMIT = 32'(4 * DEPTH);

   // Handshake: a byte transfers on a rising edge where rx_valid && rx_ready are
   // both high; rx_ready is high only in LOAD and never depends on rx_valid.

   state_t           state, state_next;
   logic [1:0]       byte_cnt;
   logic [CNT_W-1:0] word_cnt;
   logic [CNT_W-1:0] len_q;
   logic [CNT_W-1:0] len_clamp;
   logic             byte_acc;
   logic             last_word;

   assign len_clamp = (load_len > DEPTH_C) ? DEPTH_C : load_len;
   // A byte arriving alongside load_start belongs to the abandoned load.
   assign byte_acc  = (state == S_LOAD) && rx_valid && !load_start;
   assign last_word = ((word_cnt + CNT_W'(1)) == len_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      rx_ready   = 1'b0;
      im_we      = 1'b0;
      cpu_rst_n  = 1'b0;
      im_addr    = word_cnt[ADDR_W-1:0];
      case (state)
         S_IDLE: begin
            state_next = state;
         end
         S_LOAD: begin
            rx_ready = 1'b1;
            if (byte_acc && (byte_cnt == 2'd3)) begin
               state_next = S_WRITE;
            end
         end
         S_WRITE: begin
            im_we      = 1'b1;
            state_next = last_word ? S_RUN : S_LOAD;
         end
         S_RUN: begin
            cpu_rst_n = 1'b1;
            im_addr   = cpu_pc[ADDR_W+1:2];
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
      // A new load request wins from any state, including mid-word.
      if (load_start) begin
         state_next = (len_clamp == '0) ? S_RUN : S_LOAD;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt <= '0;
         word_cnt <= '0;
         len_q    <= '0;
         im_wdata <= '0;
      end else if (load_start) begin
         byte_cnt <= '0;
         word_cnt <= '0;
         len_q    <= len_clamp;
         im_wdata <= '0;
      end else begin
         if (byte_acc) begin
            im_wdata[{byte_cnt, 3'b000} +: 8] <= rx_byte;
            byte_cnt <= byte_cnt + 2'd1;
         end
         if (state == S_WRITE) begin
            word_cnt <= word_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_done   <= 1'b0;
         fetch_fault <= 1'b0;
      end else begin
         load_done <= (state_next == S_RUN) && (state != S_RUN);
         if (load_start) begin
            fetch_fault <= 1'b0;
         end else if ((state == S_RUN) && (cpu_pc >= PC_LIMIT)) begin
            fetch_fault <= 1'b1;
         end
      end
   end

   assign fsm_state = state;

endmodule
